// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction classes, ALU command codes and ARM condition codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    ALU_WB  = 4'd4,
    MEM_ADR = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WB  = 4'd7,
    MEM_WR  = 4'd8,
    BRANCH  = 4'd9
  } state_t;

  // Instruction classes carried on op
  localparam logic [1:0] OP_DP  = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR  = 2'd2;
  localparam logic [1:0] OP_UND = 2'd3;

  // ALU command codes (funct[4:1] encoding)
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  // Compare-type commands only set flags, they never write a register
  function automatic logic is_compare(input logic [3:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_TST);
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluation: decides whether an instruction executes given
// its condition field and the registered {N,Z,C,V} flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Standard ARM condition table; code 15 never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset controller: ten-state FSM producing datapath
// enables/selects, plus the registered condition flags.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            cond,
  input  logic [3:0]            rd,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            flags,
  output logic [3:0]            state
);

  state_t     state_reg, state_next;
  logic [3:0] flags_reg;
  logic [3:0] alu_cmd;
  logic       cond_pass;
  logic       mem_done;
  logic       rd_is_pc;

  // Memory handshake collapses to "always done" when stalling is disabled
  assign mem_done = !MEM_WAIT_EN || mem_ready;
  assign rd_is_pc = (rd == 4'd15);

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_reg),
    .pass  (cond_pass)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  // Flags are captured only at the end of a flag-setting ALU writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  flags_reg <= 4'b0000;
    else if (state_reg == ALU_WB && funct[0]) flags_reg <= alu_flags;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    imm_src    = 2'd0;
    alu_cmd    = 4'd0;
    case (state_reg)
      FETCH: begin
        alu_src_b = 2'd2;
        if (mem_done) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (!cond_pass || op == OP_UND) state_next = FETCH;
        else if (op == OP_DP)           state_next = funct[5] ? EXEC_I : EXEC_R;
        else if (op == OP_MEM)          state_next = MEM_ADR;
        else                            state_next = BRANCH;
      end
      EXEC_R: begin
        alu_cmd    = funct[4:1];
        state_next = ALU_WB;
      end
      EXEC_I: begin
        alu_cmd    = funct[4:1];
        imm_src    = 2'd0;
        state_next = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = !is_compare(funct[4:1]);
        pc_write   = !is_compare(funct[4:1]) && rd_is_pc;
        result_src = 2'd0;
        state_next = FETCH;
      end
      MEM_ADR: begin
        imm_src    = 2'd1;
        alu_src_b  = 2'd1;
        alu_cmd    = funct[3] ? CMD_ADD : CMD_SUB;
        state_next = funct[0] ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        adr_src = 1'b1;
        if (mem_done) state_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'd1;
        pc_write   = rd_is_pc;
        state_next = FETCH;
      end
      MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_done) state_next = FETCH;
      end
      BRANCH: begin
        imm_src    = 2'd2;
        alu_src_b  = 2'd1;
        alu_cmd    = CMD_ADD;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Register source selects depend only on the instruction, not the state
  assign reg_src     = {(op == OP_MEM) && !funct[0], op == OP_BR};
  assign alu_control = ALU_CTRL_W'(alu_cmd);
  assign flags       = flags_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes the expected
// per-cycle controller outputs, a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                         S_EXEC_I = 4'd3, S_ALU_WB = 4'd4, S_MEM_ADR = 4'd5,
                         S_MEM_RD = 4'd6, S_MEM_WB = 4'd7, S_MEM_WR = 4'd8,
                         S_BRANCH = 4'd9;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr, asa;
    logic [1:0] asb, rs, imm, rsrc;
    logic [3:0] aluc;
    logic [3:0] fl;
  } exp_t;

  typedef struct {
    string name;
    exp_t  v;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond, rd, alu_flags;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src;
  logic [3:0] alu_control, flags, state;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .cond(cond), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .reg_src(reg_src), .alu_control(alu_control), .flags(flags), .state(state)
  );

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                              input logic rw, input logic mw, input logic adr,
                              input logic [1:0] asb, input logic [1:0] rs,
                              input logic [1:0] imm, input logic [3:0] aluc,
                              input logic [1:0] rsrc, input logic [3:0] fl);
    exp_t e;
    e.st = st; e.pcw = pcw; e.irw = irw; e.rw = rw; e.mw = mw; e.adr = adr;
    e.asa = 1'b0; e.asb = asb; e.rs = rs; e.imm = imm; e.rsrc = rsrc;
    e.aluc = aluc; e.fl = fl;
    return e;
  endfunction

  // Common per-state shorthands
  function automatic exp_t e_fetch(input logic [1:0] rsrc, input logic [3:0] fl);
    return mk(S_FETCH, 1, 1, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd0, rsrc, fl);
  endfunction
  function automatic exp_t e_stall(input logic [1:0] rsrc, input logic [3:0] fl);
    return mk(S_FETCH, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd0, rsrc, fl);
  endfunction
  function automatic exp_t e_decode(input logic [1:0] rsrc, input logic [3:0] fl);
    return mk(S_DECODE, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, rsrc, fl);
  endfunction

  // One clock of stimulus: record the expectation, then advance a cycle
  task automatic cyc(input string name, input exp_t e);
    sb_entry_t ent;
    ent.name = name;
    ent.v    = e;
    sb.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] c, input logic [3:0] r,
                           input logic [3:0] af);
    op = o; funct = f; cond = c; rd = r; alu_flags = af;
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t ent;
      exp_t      act;
      ent = sb.pop_front();
      act = '{st: state, pcw: pc_write, irw: ir_write, rw: reg_write,
              mw: mem_write, adr: adr_src, asa: alu_src_a, asb: alu_src_b,
              rs: result_src, imm: imm_src, rsrc: reg_src,
              aluc: alu_control, fl: flags};
      checks++;
      if (act !== ent.v) begin
        errors++;
        $display("FAIL %s: got state=%0d outs=%h required state=%0d outs=%h",
                 ent.name, act.st, act, ent.v.st, ent.v);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1;
    set_instr(2'd0, 6'b101000, 4'b1110, 4'd1, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", e_fetch(2'b00, 4'b0000));
    rst = 1'b0;

    // ADD R1,R2,#5 (no S): flags must stay 0000 despite alu_flags=1111
    cyc("add_fetch",  e_fetch(2'b00, 4'b0000));
    cyc("add_decode", e_decode(2'b00, 4'b0000));
    cyc("add_exec_i", mk(S_EXEC_I, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'b0100, 2'b00, 4'b0000));
    cyc("add_alu_wb", mk(S_ALU_WB, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0000));
    $display("instr ADD R1,R2,#5 issued");

    // SUBS R3,R3,#1 producing Z
    set_instr(2'd0, 6'b100101, 4'b1110, 4'd3, 4'b0100);
    cyc("subs_fetch",  e_fetch(2'b00, 4'b0000));
    cyc("subs_decode", e_decode(2'b00, 4'b0000));
    cyc("subs_exec_i", mk(S_EXEC_I, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'b0010, 2'b00, 4'b0000));
    cyc("subs_alu_wb", mk(S_ALU_WB, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0000));
    $display("instr SUBS R3,R3,#1 issued");

    // BEQ taken (Z=1): three cycles, pc_write in BRANCH
    set_instr(2'd2, 6'b000000, 4'b0000, 4'd0, 4'b0000);
    cyc("beq_fetch",  e_fetch(2'b01, 4'b0100));
    cyc("beq_decode", e_decode(2'b01, 4'b0100));
    cyc("beq_branch", mk(S_BRANCH, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd2, 4'b0100, 2'b01, 4'b0100));
    $display("instr BEQ issued");

    // BNE not taken: back to FETCH from DECODE with no writes
    set_instr(2'd2, 6'b000000, 4'b0001, 4'd0, 4'b0000);
    cyc("bne_fetch",  e_fetch(2'b01, 4'b0100));
    cyc("bne_decode", e_decode(2'b01, 4'b0100));
    $display("instr BNE issued");

    // LDR R4 with three wait cycles in MEM_RD
    set_instr(2'd1, 6'b011001, 4'b1110, 4'd4, 4'b0000);
    cyc("ldr_fetch",   e_fetch(2'b00, 4'b0100));
    cyc("ldr_decode",  e_decode(2'b00, 4'b0100));
    cyc("ldr_mem_adr", mk(S_MEM_ADR, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 4'b0100, 2'b00, 4'b0100));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("ldr_mem_rd_wait", mk(S_MEM_RD, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0100));
    mem_ready = 1'b1;
    cyc("ldr_mem_rd_done", mk(S_MEM_RD, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0100));
    cyc("ldr_mem_wb", mk(S_MEM_WB, 0, 0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 4'd0, 2'b00, 4'b0100));
    $display("instr LDR R4 (3 waits) issued");

    // LDR PC with down offset: SUB address, pc_write in MEM_WB
    set_instr(2'd1, 6'b010001, 4'b1110, 4'd15, 4'b0000);
    cyc("ldrpc_fetch",   e_fetch(2'b00, 4'b0100));
    cyc("ldrpc_decode",  e_decode(2'b00, 4'b0100));
    cyc("ldrpc_mem_adr", mk(S_MEM_ADR, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 4'b0010, 2'b00, 4'b0100));
    cyc("ldrpc_mem_rd",  mk(S_MEM_RD, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0100));
    cyc("ldrpc_mem_wb",  mk(S_MEM_WB, 1, 0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 4'd0, 2'b00, 4'b0100));
    $display("instr LDR PC issued");

    // ADD PC,Rn,Rm (register form): pc_write in ALU_WB
    set_instr(2'd0, 6'b001000, 4'b1110, 4'd15, 4'b0000);
    cyc("addpc_fetch",  e_fetch(2'b00, 4'b0100));
    cyc("addpc_decode", e_decode(2'b00, 4'b0100));
    cyc("addpc_exec_r", mk(S_EXEC_R, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'b0100, 2'b00, 4'b0100));
    cyc("addpc_alu_wb", mk(S_ALU_WB, 1, 1'b0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0100));
    $display("instr ADD PC issued");

    // CMP with rd=15: no register or PC write, flags load 0010
    set_instr(2'd0, 6'b110101, 4'b1110, 4'd15, 4'b0010);
    cyc("cmp_fetch",  e_fetch(2'b00, 4'b0100));
    cyc("cmp_decode", e_decode(2'b00, 4'b0100));
    cyc("cmp_exec_i", mk(S_EXEC_I, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'b1010, 2'b00, 4'b0100));
    cyc("cmp_alu_wb", mk(S_ALU_WB, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 2'b00, 4'b0100));
    $display("instr CMP issued");

    // Undefined class: discarded in DECODE
    set_instr(2'd3, 6'b000000, 4'b1110, 4'd0, 4'b0000);
    cyc("und_fetch",  e_fetch(2'b00, 4'b0010));
    cyc("und_decode", e_decode(2'b00, 4'b0010));
    $display("instr UNDEF issued");

    // STR: fetch stall, enter MEM_WR, then reset asserted mid-cycle
    set_instr(2'd1, 6'b011000, 4'b1110, 4'd2, 4'b0000);
    mem_ready = 1'b0;
    cyc("str_fetch_stall", e_stall(2'b10, 4'b0010));
    mem_ready = 1'b1;
    cyc("str_fetch",   e_fetch(2'b10, 4'b0010));
    cyc("str_decode",  e_decode(2'b10, 4'b0010));
    cyc("str_mem_adr", mk(S_MEM_ADR, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 4'b0100, 2'b10, 4'b0010));
    mem_ready = 1'b0;
    cyc("str_mem_wr_wait", mk(S_MEM_WR, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'b10, 4'b0010));
    mem_ready = 1'b1;
    rst = 1'b1;
    cyc("str_async_reset", e_fetch(2'b10, 4'b0000));
    rst = 1'b0;
    $display("instr STR aborted by reset");

    // Fresh STR after reset, no waits: four cycles
    cyc("str2_fetch",   e_fetch(2'b10, 4'b0000));
    cyc("str2_decode",  e_decode(2'b10, 4'b0000));
    cyc("str2_mem_adr", mk(S_MEM_ADR, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 4'b0100, 2'b10, 4'b0000));
    cyc("str2_mem_wr",  mk(S_MEM_WR, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 4'd0, 2'b10, 4'b0000));
    cyc("str2_next_fetch", e_fetch(2'b10, 4'b0000));
    $display("instr STR R2 issued");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", sb.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
